// File: rtl/hdlc_tx_if.sv
// Byte stream handshake feeding the HDLC transmitter holding register.
interface hdlc_tx_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/hdlc_tx_ctrl.sv
// HDLC-style transmitter: opening flag, LSB-first data with zero stuffing, closing flag, abort on underrun.
// Optional macro IDLE_FLAGS_EN: idle line carries back-to-back flags instead of constant 1.
module hdlc_tx_ctrl #(
  parameter int unsigned MAX_ONES  = 5,
  parameter int unsigned ABORT_LEN = 7,
  parameter logic [7:0]  FLAG      = 8'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  hdlc_tx_if.slave   stream,
  output logic       tx_bit,
  output logic       tx_active,
  output logic       stuffed,
  output logic       underrun
);

  localparam int unsigned ONES_W  = $clog2(MAX_ONES + 1);
  localparam int unsigned CNT_MAX = (ABORT_LEN > 8) ? ABORT_LEN : 8;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, OPEN, DATA, STUFF, CLOSE, ABORT} state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } hold_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  hold_t             hold_q;
  logic              hold_full_q;
  logic [7:0]        shift_q;
  logic              last_q;
  logic              load_c;
  logic              boundary_c;
  logic              data_bit_c;
  logic              bit_d, act_d, stuff_d, under_d;

  // In DATA, cnt is the index of the next bit; 8 marks a byte boundary awaiting the end-of-byte decision.
  assign boundary_c     = (state_q == DATA) && (cnt_q == CNT_W'(8));
  assign data_bit_c     = boundary_c ? hold_q.data[0] : shift_q[cnt_q[2:0]];
  assign stream.s_ready = ~hold_full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, bit/ones counters and hold->shift transfer; everything holds when bit_en is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    load_c  = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          ones_d = '0;
`ifdef IDLE_FLAGS_EN
          if (cnt_q == '0 && hold_full_q) begin
            state_d = OPEN;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = (cnt_q == CNT_W'(7)) ? '0 : cnt_q + CNT_W'(1);
          end
`else
          if (hold_full_q) begin
            state_d = OPEN;
            cnt_d   = CNT_W'(1);
          end
`endif
        end
        OPEN: begin
          ones_d = '0;
          if (cnt_q == CNT_W'(7)) begin
            state_d = DATA;
            cnt_d   = CNT_W'(8);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (boundary_c && last_q) begin
            state_d = CLOSE;
            cnt_d   = CNT_W'(1);
            ones_d  = '0;
          end else if (boundary_c && !hold_full_q) begin
            state_d = ABORT;
            cnt_d   = CNT_W'(1);
            ones_d  = '0;
          end else begin
            load_c = boundary_c;
            cnt_d  = boundary_c ? CNT_W'(1) : cnt_q + CNT_W'(1);
            if (data_bit_c) begin
              ones_d = ones_q + ONES_W'(1);
              if (ones_d == ONES_W'(MAX_ONES)) state_d = STUFF;
            end else begin
              ones_d = '0;
            end
          end
        end
        STUFF: begin
          ones_d  = '0;
          state_d = DATA;
        end
        CLOSE: begin
          ones_d = '0;
          if (cnt_q == CNT_W'(7)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ABORT: begin
          if (cnt_q == CNT_W'(ABORT_LEN - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          ones_d  = '0;
        end
      endcase
    end
  end

  // Line value and status to be registered on this edge; pulses default low, line/active hold.
  always_comb begin
    bit_d   = tx_bit;
    act_d   = tx_active;
    stuff_d = 1'b0;
    under_d = 1'b0;
    if (bit_en) begin
      act_d = 1'b1;
      case (state_q)
        IDLE: begin
`ifdef IDLE_FLAGS_EN
          bit_d = FLAG[cnt_q[2:0]];
          act_d = (cnt_q == '0) && hold_full_q;
`else
          bit_d = hold_full_q ? FLAG[0] : 1'b1;
          act_d = hold_full_q;
`endif
        end
        OPEN:  bit_d = FLAG[cnt_q[2:0]];
        DATA: begin
          if (boundary_c && last_q) begin
            bit_d = FLAG[0];
          end else if (boundary_c && !hold_full_q) begin
            bit_d   = 1'b1;
            under_d = 1'b1;
          end else begin
            bit_d = data_bit_c;
          end
        end
        STUFF: begin
          bit_d   = 1'b0;
          stuff_d = 1'b1;
        end
        CLOSE: bit_d = FLAG[cnt_q[2:0]];
        ABORT: bit_d = 1'b1;
        default: begin
          bit_d = 1'b1;
          act_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      ones_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      last_q      <= 1'b0;
      tx_bit      <= 1'b1;
      tx_active   <= 1'b0;
      stuffed     <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      tx_bit    <= bit_d;
      tx_active <= act_d;
      stuffed   <= stuff_d;
      underrun  <= under_d;
      // Hold accepts only when empty, so a load and an accept never coincide.
      if (load_c) begin
        hold_full_q <= 1'b0;
      end else if (stream.s_valid && !hold_full_q) begin
        hold_q      <= '{last: stream.s_last, data: stream.s_data};
        hold_full_q <= 1'b1;
      end
      if (load_c) begin
        shift_q <= hold_q.data;
        last_q  <= hold_q.last;
      end else if (bit_en && state_q == OPEN) begin
        last_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdlc_tx_ctrl.sv
// Directed bench for hdlc_tx_ctrl: idle line, single/multi-byte frames, stuffing, underrun abort, mid-frame reset.
`timescale 1ns/1ps
module tb_hdlc_tx_ctrl;
  logic clk = 1'b0;
  logic rst, bit_en;
  logic tx_bit, tx_active, stuffed, underrun;

  hdlc_tx_if bus();

  hdlc_tx_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .stream    (bus),
    .tx_bit    (tx_bit),
    .tx_active (tx_active),
    .stuffed   (stuffed),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q_data [$];
  logic        q_last [$];
  logic [63:0] got;
  int          nbits, n_stuff, n_under, stuff_pos, under_pos, first_tick, frz_bad;
  logic        ready_after, done, end_bit;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive bit_en and offer the next queued byte when the hold is empty; sample #1 after the edge.
  task automatic tick(input logic en);
    @(negedge clk);
    bit_en = en;
    if (q_data.size() > 0 && bus.s_ready) begin
      bus.s_valid = 1'b1;
      bus.s_data  = q_data.pop_front();
      bus.s_last  = q_last.pop_front();
    end else begin
      bus.s_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Bit period of two clocks (bit_en on even ticks); captures every active line bit until tx_active falls.
  task automatic run_frame();
    logic prev, seen;
    got = '0; nbits = 0; n_stuff = 0; n_under = 0;
    stuff_pos = 999; under_pos = 999; first_tick = 999; frz_bad = 0;
    done = 1'b0; seen = 1'b0; ready_after = 1'b1; end_bit = 1'b0;
    for (int t = 0; t < 400; t++) begin
      prev = tx_bit;
      tick((t % 2) == 0);
      if (t == 0) ready_after = bus.s_ready;
      if ((t % 2) == 0) begin
        if (tx_active) begin
          if (!seen) first_tick = t;
          seen = 1'b1;
          if (stuffed)  begin n_stuff++; stuff_pos = nbits; end
          if (underrun) begin n_under++; under_pos = nbits; end
          got = {got[62:0], tx_bit};
          nbits++;
        end else if (seen) begin
          done    = 1'b1;
          end_bit = tx_bit;
          break;
        end
      end else if (tx_bit !== prev || stuffed || underrun) begin
        frz_bad++;
      end
    end
  endtask

  task automatic frame_checks(input string tag, input logic [63:0] exp_bits, input int exp_n,
                              input int exp_stuff, input int exp_spos, input int exp_under, input int exp_upos);
    check({tag, "_done"},      64'(done), 64'd1);
    check({tag, "_bits"},      got, exp_bits);
    check({tag, "_len"},       64'(nbits), 64'(exp_n));
    check({tag, "_nstuff"},    64'(n_stuff), 64'(exp_stuff));
    check({tag, "_stuffpos"},  64'(stuff_pos), 64'(exp_spos));
    check({tag, "_nunder"},    64'(n_under), 64'(exp_under));
    check({tag, "_underpos"},  64'(under_pos), 64'(exp_upos));
    check({tag, "_freeze"},    64'(frz_bad), 64'd0);
    check({tag, "_ready_low"}, 64'(ready_after), 64'd0);
`ifndef IDLE_FLAGS_EN
    check({tag, "_latency"},   64'(first_tick), 64'd2);
    check({tag, "_idle_bit"},  64'(end_bit), 64'd1);
`endif
  endtask

  initial begin
    logic [7:0] flag_v;
    flag_v = 8'h7E;
    rst = 1'b1; bit_en = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_bit",    64'(tx_bit), 64'd1);
    check("rst_tx_active", 64'(tx_active), 64'd0);
    check("rst_s_ready",   64'(bus.s_ready), 64'd1);
    check("rst_stuffed",   64'(stuffed), 64'd0);
    check("rst_underrun",  64'(underrun), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle line with 20 bit strobes and no data
    for (int i = 0; i < 40; i++) begin
      tick((i % 2) == 0);
      if ((i % 2) == 0) begin
`ifdef IDLE_FLAGS_EN
        check("idle_flag_bit", 64'(tx_bit), 64'(flag_v[(i / 2) % 8]));
`else
        check("idle_bit", 64'(tx_bit), 64'd1);
`endif
        check("idle_active", 64'(tx_active), 64'd0);
      end
    end
    check("idle_s_ready", 64'(bus.s_ready), 64'd1);

    // 0x00 single-byte frame
    q_data.push_back(8'h00); q_last.push_back(1'b1);
    run_frame();
    frame_checks("f00", 64'b01111110_00000000_01111110, 24, 0, 999, 0, 999);

    // 0xFF single-byte frame: stuff after five ones
    q_data.push_back(8'hFF); q_last.push_back(1'b1);
    run_frame();
    frame_checks("fff", 64'b01111110_111110111_01111110, 25, 1, 13, 0, 999);

    // 0xF0 then 0x03: ones run crosses the byte boundary
    q_data.push_back(8'hF0); q_last.push_back(1'b0);
    q_data.push_back(8'h03); q_last.push_back(1'b1);
    run_frame();
    frame_checks("f2b", 64'b01111110_00001111_1_0_1000000_01111110, 33, 1, 17, 0, 999);

    // 0x55 without last and nothing behind it: underrun abort
    q_data.push_back(8'h55); q_last.push_back(1'b0);
    run_frame();
    frame_checks("abt", 64'b01111110_10101010_1111111, 23, 0, 999, 1, 16);

    // Reset while 0xAA is mid-byte and 0x0F waits in the hold
    q_data.push_back(8'hAA); q_last.push_back(1'b0);
    q_data.push_back(8'h0F); q_last.push_back(1'b1);
    got = '0; nbits = 0;
    for (int t = 0; t < 200 && nbits < 11; t++) begin
      tick((t % 2) == 0);
      if ((t % 2) == 0 && tx_active) begin
        got = {got[62:0], tx_bit};
        nbits++;
      end
    end
    check("mid_prefix_bits", got, 64'b01111110_010);
    check("mid_prefix_len",  64'(nbits), 64'd11);
    check("mid_hold_full",   64'(bus.s_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_bit",    64'(tx_bit), 64'd1);
    check("mid_rst_tx_active", 64'(tx_active), 64'd0);
    check("mid_rst_s_ready",   64'(bus.s_ready), 64'd1);
    check("mid_rst_stuffed",   64'(stuffed), 64'd0);
    @(negedge clk);
    rst = 1'b0; bit_en = 1'b0; bus.s_valid = 1'b0;
    q_data.delete(); q_last.delete();

    // Clean frame after the reset
    q_data.push_back(8'h81); q_last.push_back(1'b1);
    run_frame();
    frame_checks("post", 64'b01111110_10000001_01111110, 24, 0, 999, 0, 999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
